// File: rtl/rs232_avalon_slave.sv
// RS-232 UART with an Avalon-MM slave port.
// Registers: RX data (0x0), TX data (0x4), STATUS (0x8). Every access takes
// exactly one wait state. Single-byte holding registers in each direction.
module rs232_avalon_slave #(
    parameter int CLK_DIV = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // bus / status state
    logic        ack_q, ack_d;
    logic        rrdy_q, rrdy_d, trdy_q, trdy_d, roe_q, roe_d, fe_q, fe_d;
    logic [7:0]  rx_hold_q, rx_hold_d, tx_hold_q, tx_hold_d;
    // receiver: [0]/[1] synchronizer, [2] previous synchronized value for edge detect
    logic [2:0]  rx_sync_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    // transmitter
    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        txd_q, txd_d;

    logic rx_in, rx_fall, rx_end, tx_pick;
    logic done, rd_done, wr_done, a_rx, a_tx, a_st;
    logic rd_rx, wr_st, tx_acc, rx_load, rx_ovr, rx_ferr;
    logic unused_wdata;

    assign unused_wdata = ^avm_writedata[31:8];
    assign rx_in   = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];
    assign uart_txd = txd_q;

    // Bus handshake: stall the first cycle of each request, complete the next.
    // A write that arrives together with a read is ignored.
    always_comb begin
        ack_d           = (avm_read | avm_write) & ~ack_q;
        avm_waitrequest = (avm_read | avm_write) & ~ack_q & ~avm_rst;
        done    = (avm_read | avm_write) & ack_q & ~avm_rst;
        rd_done = done & avm_read;
        wr_done = done & avm_write & ~avm_read;
        a_rx    = (avm_address == 5'd0);
        a_tx    = (avm_address == 5'd4);
        a_st    = (avm_address == 5'd8);
        avm_readdata = 32'd0;
        if (rd_done && a_rx) avm_readdata = {24'd0, rx_hold_q};
        if (rd_done && a_st) avm_readdata = {24'd0, rrdy_q, trdy_q, 2'b00, roe_q, 1'b0, fe_q, 1'b0};
    end

    // Holding registers and status flags; side effects only on completion.
    // An RX read completing as a byte lands frees the slot, so no overrun.
    always_comb begin
        rd_rx   = rd_done & a_rx;
        wr_st   = wr_done & a_st;
        tx_acc  = wr_done & a_tx & trdy_q;
        rx_load = rx_end & rx_in & (~rrdy_q | rd_rx);
        rx_ovr  = rx_end & rx_in & rrdy_q & ~rd_rx;
        rx_ferr = rx_end & ~rx_in;
        rrdy_d    = rx_load | (rrdy_q & ~rd_rx);
        roe_d     = rx_ovr  | (roe_q & ~wr_st);
        fe_d      = rx_ferr | (fe_q & ~wr_st);
        rx_hold_d = rx_load ? rx_sh_q : rx_hold_q;
        tx_hold_d = tx_acc ? avm_writedata[7:0] : tx_hold_q;
        trdy_d    = tx_pick | (trdy_q & ~tx_acc);
    end

    // RX next state: centre on the start bit, then one sample per bit period.
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
            RX_START: if (rx_cnt_q == HALF_LAST) rx_state_d = rx_in ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt_q == DIV_LAST && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_cnt_q == DIV_LAST) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // RX datapath: bit timer, LSB-first shifter, stop-bit sample strobe.
    always_comb begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_end   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                rx_bit_d = 3'd0;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) rx_cnt_d = 16'd0;
            RX_DATA: if (rx_cnt_q == DIV_LAST) begin
                rx_cnt_d = 16'd0;
                rx_sh_d  = {rx_in, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
            end
            RX_STOP: if (rx_cnt_q == DIV_LAST) begin
                rx_cnt_d = 16'd0;
                rx_end   = 1'b1;
            end
            default: rx_cnt_d = 16'd0;
        endcase
    end

    // TX next state: a pending byte at the end of the stop bit chains straight
    // into the next start bit so back-to-back frames have no idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE:  if (!trdy_q) tx_state_d = TX_START;
            TX_START: if (tx_cnt_q == DIV_LAST) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_cnt_q == DIV_LAST && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_cnt_q == DIV_LAST) tx_state_d = trdy_q ? TX_IDLE : TX_START;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // TX datapath: byte pickup, bit timer, shifter and registered line level.
    always_comb begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_pick  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = 16'd0;
                tx_bit_d = 3'd0;
                if (!trdy_q) begin
                    tx_pick = 1'b1;
                    tx_sh_d = tx_hold_q;
                end
            end
            TX_START: if (tx_cnt_q == DIV_LAST) tx_cnt_d = 16'd0;
            TX_DATA: if (tx_cnt_q == DIV_LAST) begin
                tx_cnt_d = 16'd0;
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_bit_d = tx_bit_q + 3'd1;
            end
            TX_STOP: if (tx_cnt_q == DIV_LAST) begin
                tx_cnt_d = 16'd0;
                tx_bit_d = 3'd0;
                if (!trdy_q) begin
                    tx_pick = 1'b1;
                    tx_sh_d = tx_hold_q;
                end
            end
            default: tx_cnt_d = 16'd0;
        endcase
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_sh_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // State register for bus, flags, both FSMs and their datapaths.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            ack_q      <= 1'b0;
            rrdy_q     <= 1'b0;
            trdy_q     <= 1'b1;
            roe_q      <= 1'b0;
            fe_q       <= 1'b0;
            rx_hold_q  <= 8'd0;
            tx_hold_q  <= 8'd0;
            rx_sync_q  <= 3'b111;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            txd_q      <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            rrdy_q     <= rrdy_d;
            trdy_q     <= trdy_d;
            roe_q      <= roe_d;
            fe_q       <= fe_d;
            rx_hold_q  <= rx_hold_d;
            tx_hold_q  <= tx_hold_d;
            rx_sync_q  <= {rx_sync_q[1:0], uart_rxd};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
        end
    end

endmodule
